// File: rtl/sensor_regfile.sv
// sensor_regfile: per-ID sensor word table between the receive path and the
// transmit builder. Each entry holds a data word, a valid flag and a saturating
// age counter (cycles since the last write). Reads are single-outstanding with a
// fixed response latency; out-of-range IDs return an error response, and
// out-of-range writes are dropped with a one-cycle notification pulse.
module sensor_regfile #(
    parameter int ID_W      = 8,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int RD_LAT    = 3,
    parameter int AGE_W     = 16,
    parameter int CLR_ON_RD = 0
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   store_data_f,
    input  logic [ID_W+DATA_W-1:0] store_data,
    input  logic                   flush,
    input  logic                   req_id_f,
    input  logic [ID_W-1:0]        req_id,
    output logic                   req_ready,
    output logic [DATA_W-1:0]      req_data,
    output logic                   req_data_f,
    output logic                   req_valid,
    output logic [AGE_W-1:0]       req_age,
    output logic                   req_err,
    output logic                   store_drop
);

    // Latency counter is sized for the largest legal RD_LAT (15).
    localparam int               CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);
    // One extra bit so DEPTH = 2^ID_W is representable in the range compare.
    localparam logic [ID_W:0]    DEPTH_C  = (ID_W + 1)'(DEPTH);
    localparam logic [AGE_W-1:0] AGE_MAX  = '1;

    // Age never wraps: once at all-ones it stays there until the next write.
    function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
        if (a == AGE_MAX) begin
            return a;
        end
        return a + AGE_W'(1);
    endfunction

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_accept;
    logic             w_rsp;

    logic [ID_W-1:0]   r_rd_id;
    logic              w_rd_in_range;

    logic [ID_W-1:0]   w_wr_id;
    logic [DATA_W-1:0] w_wr_dat;
    logic              w_wr_in_range;

    logic [DATA_W-1:0] w_ent_data  [DEPTH];
    logic              w_ent_valid [DEPTH];
    logic [AGE_W-1:0]  w_ent_age   [DEPTH];

    logic [DATA_W-1:0] w_sel_data;
    logic              w_sel_valid;
    logic [AGE_W-1:0]  w_sel_age;

    logic [DATA_W-1:0] r_req_data;
    logic              r_req_data_f;
    logic              r_req_valid;
    logic [AGE_W-1:0]  r_req_age;
    logic              r_req_err;
    logic              r_store_drop;

    assign w_wr_id       = store_data[ID_W+DATA_W-1:DATA_W];
    assign w_wr_dat      = store_data[DATA_W-1:0];
    assign w_wr_in_range = ({1'b0, w_wr_id} < DEPTH_C);
    assign w_rd_in_range = ({1'b0, r_rd_id} < DEPTH_C);

    // Ready is simply "no request outstanding"; it rises right after the
    // response edge, in the same cycle req_data_f is high.
    assign req_ready = (r_state == ST_IDLE);

    // Request FSM state register, latency counter and latched request ID.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rd_id <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_rd_id <= req_id;
            end
        end
    end

    // Next-state logic: accept in IDLE, count RD_LAT edges in WAIT, respond.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_rsp       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_id_f) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            ST_WAIT: begin
                if (r_cnt == CNT_LAST) begin
                    w_rsp       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Per-entry storage. A write always wins over flush and clear-on-read
    // for its own entry; an unwritten entry ages by one each edge.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        logic              w_wr_hit;
        logic              w_rd_clr;
        logic [DATA_W-1:0] r_data;
        logic              r_valid;
        logic [AGE_W-1:0]  r_age;

        assign w_wr_hit = store_data_f && (w_wr_id == ID_W'(g));
        assign w_rd_clr = (CLR_ON_RD != 0) && w_rsp && (r_rd_id == ID_W'(g));

        // Entry data, valid flag and saturating age.
        always_ff @(posedge sys_clk or negedge sys_rst) begin
            if (!sys_rst) begin
                r_data  <= '0;
                r_valid <= 1'b0;
                r_age   <= AGE_MAX;
            end else if (w_wr_hit) begin
                r_data  <= w_wr_dat;
                r_valid <= 1'b1;
                r_age   <= '0;
            end else begin
                r_age <= age_sat_inc(r_age);
                if (flush || w_rd_clr) begin
                    r_valid <= 1'b0;
                end
            end
        end

        assign w_ent_data[g]  = r_data;
        assign w_ent_valid[g] = r_valid;
        assign w_ent_age[g]   = r_age;
    end

    // Read mux on the latched ID; an out-of-range ID matches no entry and
    // falls through to the error-response values.
    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        w_sel_age   = AGE_MAX;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_rd_id == ID_W'(i)) begin
                w_sel_data  = w_ent_data[i];
                w_sel_valid = w_ent_valid[i];
                w_sel_age   = w_ent_age[i];
            end
        end
    end

    // Response capture (held until the next response) and drop notification.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_req_data   <= '0;
            r_req_data_f <= 1'b0;
            r_req_valid  <= 1'b0;
            r_req_age    <= '0;
            r_req_err    <= 1'b0;
            r_store_drop <= 1'b0;
        end else begin
            r_req_data_f <= w_rsp;
            r_store_drop <= store_data_f && !w_wr_in_range;
            if (w_rsp) begin
                r_req_data  <= w_sel_data;
                r_req_valid <= w_sel_valid;
                r_req_age   <= w_sel_age;
                r_req_err   <= !w_rd_in_range;
            end
        end
    end

    assign req_data   = r_req_data;
    assign req_data_f = r_req_data_f;
    assign req_valid  = r_req_valid;
    assign req_age    = r_req_age;
    assign req_err    = r_req_err;
    assign store_drop = r_store_drop;

endmodule

// File: doc/sensor_regfile.md
Name: sensor_regfile

Overview:
- Parametrised sensor data register table; successor to the fixed 8-entry store/request table between the rxcomb receive path and the txcea transmit builder.
- Stores per-ID sensor words and tracks per-entry valid and age (cycles since last write).
- Serves single-outstanding read requests with programmable fixed latency, ready handshake, out-of-range error and optional clear-on-read.

Parameters:
- ID_W, 8, width of sensor ID field.
- DATA_W, 32, width of sensor data word.
- DEPTH, 8, number of table entries. Legal range 1..2^ID_W. IDs >= DEPTH are out of range.
- RD_LAT, 3, cycles from request-accept edge to response edge. Legal range 1..15.
- AGE_W, 16, width of per-entry saturating age counter.
- CLR_ON_RD, 0, when 1, a successful read clears that entry's valid bit.

Ports:
- sys_clk  input  1  system clock; all logic on its rising edge.
- sys_rst  input  1  asynchronous active-low reset.
- store_data_f  input  1  write strobe, one cycle per word.
- store_data  input  ID_W+DATA_W  [ID_W+DATA_W-1:DATA_W] = ID, [DATA_W-1:0] = data.
- flush  input  1  clears all valid bits.
- req_id_f  input  1  read request strobe.
- req_id  input  ID_W  requested ID.
- req_ready  output  1  high when a request can be accepted.
- req_data  output  DATA_W  response data.
- req_data_f  output  1  one-cycle response strobe.
- req_valid  output  1  entry held valid data at response capture.
- req_age  output  AGE_W  entry age at response capture.
- req_err  output  1  requested ID >= DEPTH.
- store_drop  output  1  one-cycle pulse: write to ID >= DEPTH was discarded.

Behaviour:
- Reset (async, sys_rst low):
  - All entries: data 0, valid 0, age all-ones.
  - Outputs: req_ready 1; req_data 0; req_data_f 0; req_valid 0; req_age 0; req_err 0; store_drop 0.
  - Reset mid-request aborts the request; no response is issued.
- Write:
  - At an edge with store_data_f=1 and ID < DEPTH: the entry's data is loaded, valid is set to 1 and age is set to 0.
  - With ID >= DEPTH: nothing is stored and store_drop is 1 for the following cycle.
- Age:
  - Each entry not written this edge increments by 1, saturating at 2^AGE_W-1 (no wrap).
- Flush:
  - At an edge with flush=1, all valid bits go to 0. Data and age are untouched.
  - A same-edge write to an entry wins for that entry (valid=1).
- Request handshake:
  - A request is accepted at an edge where req_id_f=1 and req_ready=1. The ID is latched and an internal counter starts.
  - req_id_f while req_ready=0 is ignored (no queueing, no retrigger).
  - req_ready is 0 from the accept edge until the response edge. It returns to 1 together with req_data_f, so back-to-back requests are spaced RD_LAT+1 cycles apart at minimum.
- Response:
  - At the edge exactly RD_LAT cycles after the accept edge, req_data/req_valid/req_age/req_err are registered from the table's current contents. req_data_f is 1 for that one cycle.
  - Writes at edges before the response edge are visible in the response. A write at the response edge itself is not visible (old value returned).
  - req_data, req_valid, req_age and req_err hold their values until the next response.
- Out-of-range read (ID >= DEPTH): req_err=1, req_data=0, req_valid=0, req_age=all-ones. req_data_f is still pulsed.
- Clear-on-read (CLR_ON_RD=1): at the response edge the read entry's valid bit is cleared, unless a same-edge write to that ID occurs (write wins) or req_err=1.
- State machine:
  - IDLE → (accept) → WAIT (counter 0..RD_LAT-1) → at counter = RD_LAT-1, response edge → IDLE.
  - With RD_LAT=1 the FSM goes from WAIT straight to response on the next edge.

Test Plan:
- Reset, write ID 2 = 0xDEADBEEF, wait 5 cycles, request ID 2 → with RD_LAT=3, req_data_f is high exactly 3 edges after accept; req_data=0xDEADBEEF, req_valid=1, req_err=0, req_age=7 (age 0 at the write edge, incremented at each of the 7 following edges).
- Request ID 5 with no prior write → req_data=0, req_valid=0, req_age=0xFFFF.
- Write ID 9 (DEPTH=8) → store_drop pulses one cycle and no entry changes. Request ID 9 → req_err=1, req_data=0, req_data_f pulsed.
- Accept a request for ID 1; write ID 1 = 0x11 one edge before the response edge and 0x22 at the response edge → response shows 0x11; a subsequent read shows 0x22.
- Assert req_id_f on every cycle → responses spaced RD_LAT+1 cycles apart; requests during req_ready=0 are ignored.
- CLR_ON_RD=1: write ID 3, read twice → first read gives req_valid=1, second gives req_valid=0 with the same data. Also assert flush together with a write to ID 4 → ID 4 stays valid and all other entries become invalid.
